// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: EX-side handshake and HI/LO write bus of the multiply/divide sequencer.
interface hilo_ctrl_if;
    logic        op_valid_i;
    logic [2:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        flush_i;
    logic        stall_o;
    logic        hi_we_o;
    logic [31:0] hi_o;
    logic        lo_we_o;
    logic [31:0] lo_o;
    modport master (
        output op_valid_i, op_i, src_a_i, src_b_i, flush_i,
        input  stall_o, hi_we_o, hi_o, lo_we_o, lo_o
    );
    modport slave (
        input  op_valid_i, op_i, src_a_i, src_b_i, flush_i,
        output stall_o, hi_we_o, hi_o, lo_we_o, lo_o
    );
endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: 32-step shift-add multiply / restoring divide sequencer owning HI/LO writes.
module hilo_ctrl #(
    parameter int ITER = 32
) (
    input logic       clk,
    input logic       rst_n,
    hilo_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] opa, opb;
    logic [63:0] acc;
    logic        is_div, sa, sb;
    logic        idle_ok, start, mt_hi, mt_lo, wr, sgn;
    logic [32:0] abs_a, abs_b, m_sum, r_sh, r_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, raw_a, res_hi, res_lo;
    assign idle_ok = rst_n && state == IDLE && bus.op_valid_i && !bus.flush_i;
    assign start   = idle_ok && !bus.op_i[2];
    assign mt_hi   = idle_ok && bus.op_i == 3'd4;
    assign mt_lo   = idle_ok && bus.op_i == 3'd5;
    assign wr      = rst_n && state == DONE && !bus.flush_i;
    assign sgn     = !bus.op_i[0];
    // 33-bit magnitudes so 0x80000000 needs no special handling
    assign abs_a   = (sgn && bus.src_a_i[31]) ? -{1'b1, bus.src_a_i} : {1'b0, bus.src_a_i};
    assign abs_b   = (sgn && bus.src_b_i[31]) ? -{1'b1, bus.src_b_i} : {1'b0, bus.src_b_i};
    assign m_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
    assign r_sh    = acc[63:31];
    assign r_diff  = r_sh - {1'b0, opb};
    assign prod_fix = (sa ^ sb) ? -acc : acc;
    assign quo_fix  = (sa ^ sb) ? -acc[31:0] : acc[31:0];
    assign rem_fix  = sa ? -acc[63:32] : acc[63:32];
    assign raw_a    = sa ? -opa : opa;
    assign res_hi   = !is_div ? prod_fix[63:32] : (opb == '0 ? raw_a : rem_fix);
    assign res_lo   = !is_div ? prod_fix[31:0] : (opb == '0 ? '1 : quo_fix);
    assign bus.stall_o = start || (rst_n && state == BUSY);
    assign bus.hi_we_o = wr || mt_hi;
    assign bus.lo_we_o = wr || mt_lo;
    assign bus.hi_o    = wr ? res_hi : (mt_hi ? bus.src_a_i : '0);
    assign bus.lo_o    = wr ? res_lo : (mt_lo ? bus.src_a_i : '0);
    // acc is {product} for multiply and {remainder, quotient} for divide
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
        end else if (bus.flush_i) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    state  <= BUSY;
                    cnt    <= '0;
                    opa    <= abs_a[31:0];
                    opb    <= abs_b[31:0];
                    is_div <= bus.op_i[1];
                    sa     <= sgn && bus.src_a_i[31];
                    sb     <= sgn && bus.src_b_i[31];
                    acc    <= {32'd0, bus.op_i[1] ? abs_a[31:0] : abs_b[31:0]};
                end
                BUSY: begin
                    cnt <= cnt + 6'd1;
                    acc <= is_div ? {r_diff[32] ? r_sh[31:0] : r_diff[31:0], acc[30:0], !r_diff[32]}
                                  : {m_sum, acc[31:1]};
                    if (cnt == 6'(ITER - 1)) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: randomized and directed checks of hilo_ctrl against an arithmetic reference model.
module tb_hilo_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    hilo_ctrl_if bus ();
    hilo_ctrl #(.ITER(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        hi = '0;
        lo = '0;
        if (op == 3'd0) begin
            q = sa * sb;
            p = q;
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == 3'd1) begin
            p = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = '1;
        end else begin
            if (op == 3'd2) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'({32'd0, a} / {32'd0, b});
                r = longint'({32'd0, a} % {32'd0, b});
            end
            lo = q[31:0];
            hi = r[31:0];
        end
    endfunction

    function automatic logic [31:0] pick();
        int k;
        k = $urandom_range(0, 7);
        return k == 0 ? 32'd0 : k == 1 ? 32'h8000_0000 : k == 2 ? 32'hFFFF_FFFF :
               k == 3 ? 32'($urandom_range(0, 20)) : $urandom;
    endfunction

    task automatic idle_inputs();
        bus.op_valid_i = 1'b0;
        bus.op_i = 3'd0;
        bus.src_a_i = '0;
        bus.src_b_i = '0;
        bus.flush_i = 1'b0;
    endtask

    // Starts and ends just after a rising edge; the op is presented in the call's first cycle.
    task automatic run_muldiv(input string name, input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        bit got;
        n = 0;
        got = 0;
        bus.op_valid_i = 1'b1;
        bus.op_i = op;
        bus.src_a_i = a;
        bus.src_b_i = b;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (bus.hi_we_o || bus.lo_we_o) begin
                got = 1;
                n_tests++;
                if (bus.hi_o !== eh || bus.lo_o !== el || bus.hi_we_o !== 1'b1 || bus.lo_we_o !== 1'b1 ||
                    bus.stall_o !== 1'b0 || n != 33) begin
                    n_fail++;
                    $display("FAIL %s op=%0d a=%h b=%h: got hi=%h lo=%h we=%b%b stall=%b stall_cycles=%0d, want hi=%h lo=%h we=11 stall=0 stall_cycles=33",
                             name, op, a, b, bus.hi_o, bus.lo_o, bus.hi_we_o, bus.lo_we_o, bus.stall_o, n, eh, el);
                end
            end else if (bus.stall_o === 1'b1) n++;
            @(posedge clk);
            #1;
        end
        bus.op_valid_i = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no write within 40 cycles (stall_cycles=%0d), want write at cycle 33", name, n);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.op_valid_i = 1'b1;
        bus.op_i = 3'd4;
        bus.src_a_i = 32'hDEAD_BEEF;
        #12;
        n_tests++;
        if ({bus.stall_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_mthi: got stall=%b we=%b%b hi=%h lo=%h, want all 0",
                     bus.stall_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o);
        end
        bus.op_i = 3'd0;
        #1;
        n_tests++;
        if ({bus.stall_o, bus.hi_we_o, bus.lo_we_o} !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mult: got stall=%b we=%b%b, want 000", bus.stall_o, bus.hi_we_o, bus.lo_we_o);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        run_muldiv("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_muldiv("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_muldiv("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_muldiv("div_minbym1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_muldiv("divu_by0", 3'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_muldiv("div_neg_by0", 3'd2, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    endtask

    task automatic test_mt();
        logic [2:0] op;
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            op = (i % 2 == 0) ? 3'd4 : 3'd5;
            d = (i == 0) ? 32'h1234_5678 : $urandom;
            bus.op_valid_i = 1'b1;
            bus.op_i = op;
            bus.src_a_i = d;
            bus.src_b_i = $urandom;
            @(negedge clk);
            n_tests++;
            if (bus.hi_we_o !== (op == 3'd4) || bus.lo_we_o !== (op == 3'd5) || bus.stall_o !== 1'b0 ||
                bus.hi_o !== (op == 3'd4 ? d : 32'd0) || bus.lo_o !== (op == 3'd5 ? d : 32'd0)) begin
                n_fail++;
                $display("FAIL mt op=%0d d=%h: got we=%b%b stall=%b hi=%h lo=%h", op, d,
                         bus.hi_we_o, bus.lo_we_o, bus.stall_o, bus.hi_o, bus.lo_o);
            end
            @(posedge clk);
            #1;
        end
        for (int i = 6; i < 9; i++) begin
            bus.op_i = (i == 8) ? 3'd4 : 3'(i);
            bus.flush_i = (i == 8);
            bus.src_a_i = $urandom;
            @(negedge clk);
            n_tests++;
            if ({bus.stall_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o} !== 67'd0) begin
                n_fail++;
                $display("FAIL ignored_op op=%0d flush=%b: got stall=%b we=%b%b hi=%h lo=%h, want all 0",
                         bus.op_i, bus.flush_i, bus.stall_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o);
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic [31:0] a, b, eh, el;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 3));
            a = pick();
            b = pick();
            model(op, a, b, eh, el);
            run_muldiv("random", op, a, b, eh, el);
        end
    endtask

    task automatic test_flush();
        bus.op_valid_i = 1'b1;
        bus.op_i = 3'd0;
        bus.src_a_i = 32'd1234;
        bus.src_b_i = 32'd5678;
        repeat (10) @(posedge clk);
        #1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.stall_o !== 1'b1 || bus.hi_we_o !== 1'b0 || bus.lo_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_busy: got stall=%b we=%b%b, want stall=1 we=00", bus.stall_o, bus.hi_we_o, bus.lo_we_o);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        n_tests++;
        if ({bus.stall_o, bus.hi_we_o, bus.lo_we_o} !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_idle: got stall=%b we=%b%b, want 000", bus.stall_o, bus.hi_we_o, bus.lo_we_o);
        end
        @(posedge clk);
        #1;
        run_muldiv("mult_after_flush", 3'd0, 32'hFFFF_FFF6, 32'd300, 32'hFFFF_FFFF, 32'hFFFF_F448);
        bus.op_valid_i = 1'b1;
        bus.op_i = 3'd3;
        bus.src_a_i = 32'd100;
        bus.src_b_i = 32'd7;
        repeat (33) @(posedge clk);
        #1;
        n_tests++;
        if (bus.hi_we_o !== 1'b1 || bus.hi_o !== 32'd2 || bus.lo_o !== 32'd14) begin
            n_fail++;
            $display("FAIL done_reach: got we=%b hi=%h lo=%h, want we=1 hi=2 lo=e", bus.hi_we_o, bus.hi_o, bus.lo_o);
        end
        bus.flush_i = 1'b1;
        bus.op_valid_i = 1'b0;
        #1;
        n_tests++;
        if ({bus.stall_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL flush_done: got stall=%b we=%b%b hi=%h lo=%h, want all 0",
                     bus.stall_o, bus.hi_we_o, bus.lo_we_o, bus.hi_o, bus.lo_o);
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bit saw_we;
        saw_we = 0;
        bus.op_valid_i = 1'b1;
        bus.op_i = 3'd2;
        bus.src_a_i = 32'hFFFF_FFF9;
        bus.src_b_i = 32'd2;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.op_valid_i = 1'b0;
        #1;
        n_tests++;
        if ({bus.stall_o, bus.hi_we_o, bus.lo_we_o} !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid_div: got stall=%b we=%b%b, want 000", bus.stall_o, bus.hi_we_o, bus.lo_we_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.hi_we_o !== 1'b0 || bus.lo_we_o !== 1'b0 || bus.stall_o !== 1'b0) saw_we = 1;
        end
        n_tests++;
        if (saw_we) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got write or stall after reset, want none");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        run_muldiv("b2b_multu", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
        run_muldiv("b2b_divu", 3'd3, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, 32'h0FFF_FFFF);
        run_muldiv("b2b_div", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    endtask

    initial begin
        test_reset();
        test_mt();
        test_directed();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

Multi-cycle multiply/divide sequencer that owns all writes into the HI/LO register pair. It sits beside the EX stage, accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, and runs 32-iteration shift-add multiplication and restoring division. While an operation runs, it stalls the pipeline. On completion it drives one write-enable pulse with data into `hilo_reg`.

## Interface
Parameters:
- `ITER`, 32: iterations per mul/div; fixed at 32 for the 32-bit datapath.

Ports:
- `clk`  in  1  pipeline clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid_i`  in  1  EX holds a HI/LO-class instruction this cycle.
- `op_i`  in  3  operation code:
  - 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU, 4 = MTHI, 5 = MTLO.
  - 6 and 7 are ignored (no stall, no write).
- `src_a_i`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `src_b_i`  in  32  rt operand: multiplier or divisor.
- `flush_i`  in  1  synchronous cancel of any in-flight operation.
- `stall_o`  out  1  holds EX (and earlier stages) while the operation is unfinished.
- `hi_we_o`  out  1  HI write enable to `hilo_reg`.
- `hi_o`  out  32  HI write data.
- `lo_we_o`  out  1  LO write enable to `hilo_reg`.
- `lo_o`  out  32  LO write data.

## Operation
State machine: IDLE, BUSY, DONE. The iteration counter `cnt` is 6 bits wide.

- **IDLE**
  - On `op_valid_i` with op 0-3 and `!flush_i`: latch |operands| and the sign flags (signed ops only), clear the accumulator, `cnt`←0, go to BUSY.
  - On op 4 (MTHI) or op 5 (MTLO): combinational `hi_we_o`/`lo_we_o` = 1 with `hi_o`/`lo_o` = `src_a_i` in the same cycle. No stall, stay in IDLE.
- **BUSY**
  - Each cycle performs one iteration and increments `cnt`.
  - MUL: one shift-add step of the 32×32→64 unsigned product.
  - DIV: one restoring step — shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - When `cnt` == 31 at the edge, go to DONE.
- **DONE**
  - Apply the sign fixup, assert `hi_we_o` = `lo_we_o` = 1 with the results, go to IDLE.
  - `op_valid_i` is not re-sampled in DONE; the held instruction leaves EX this cycle.

Arithmetic rules:
- MULT/MULTU: {HI,LO} = 64-bit product. For MULT, negate the product if the operand signs differ.
- DIV/DIVU: LO = quotient, HI = remainder. For DIV:
  - the quotient is negated if the operand signs differ;
  - the remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): LO = 0xFFFFFFFF, HI = `src_a_i` (raw dividend). The full 32 cycles are still used.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Absolute values are taken in 33-bit arithmetic so that 0x80000000 needs no special case before iteration.

Stall:
- `stall_o` = (IDLE & `op_valid_i` & op ∈ 0-3 & `!flush_i`) | BUSY.
- `stall_o` is low in DONE.

Flush:
- `flush_i` in BUSY or DONE returns to IDLE on the next edge with no write; write enables are forced to 0 in that cycle.
- `flush_i` has priority over every other input.

Outputs outside write cycles:
- `hi_we_o` and `lo_we_o` are 0 except in the DONE cycle and the MTHI/MTLO cycle.
- `hi_o` and `lo_o` are 0 whenever the corresponding enable is 0.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, `cnt` = 0, accumulators = 0. All outputs read 0 while reset is held.
- Releasing reset takes effect at the first rising edge after deassertion.
- Mul/div accepted in cycle T:
  - `stall_o` = 1 in cycles T..T+32 (33 cycles).
  - DONE is cycle T+33: `stall_o` = 0 and the write enables are 1.
  - `hilo_reg` shows the new values from T+34.
- Back-to-back ops: the next op can be accepted in T+34 (IDLE), never in DONE.
- MTHI/MTLO: zero latency; the write is visible in `hilo_reg` after the same edge.
- Reset mid-BUSY: immediate return to IDLE, no write issued, `stall_o` drops asynchronously.

## Test plan
- **MULT:** `src_a_i` = 0xFFFFFFFD (−3), `src_b_i` = 7. Expect `stall_o` high for exactly 33 cycles, then one DONE cycle with HI = 0xFFFFFFFF and LO = 0xFFFFFFEB.
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
- **DIV:** −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- **DIVU by zero:** 100 / 0 → after 33 stall cycles, LO = 0xFFFFFFFF and HI = 0x00000064.
- **Flush:** pulse `flush_i` in the 10th BUSY cycle → IDLE on the next edge, `stall_o` = 0, no write enable ever asserted. A new MULT issued two cycles later completes correctly.
- **MTHI/reset:**
  - MTHI 0x12345678 in IDLE → `hi_we_o` = 1 in the same cycle, `lo_we_o` = 0, `stall_o` = 0.
  - Assert `rst_n` = 0 mid-DIV → `stall_o` = 0 immediately and no write occurs.
